// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter sequencing a single-port main memory
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module mem_arbiter #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        if_ready_q, if_ready_d, if_err_q, if_err_d;
  logic        d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic        pick_data;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_fault;
  logic [32:0] range_end;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [15:0] lane_data;
  logic [31:0] load_ext;

  assign range_end  = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES};
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_mask  = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign lane_data  = 16'(mem_data_out >> lane_shift);

  always_comb begin
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'd0, lane_data[7:0]} : {{24{lane_data[7]}}, lane_data[7:0]};
      2'd1:    load_ext = uns_q ? {16'd0, lane_data} : {{16{lane_data[15]}}, lane_data};
      default: load_ext = mem_data_out;
    endcase
  end

  // Fetch is treated as a word access so the same fault checks apply to both requesters.
  always_comb begin
    pick_data = d_req && (!if_req || last_grant_q == GNT_FETCH);
    req_addr  = pick_data ? d_addr : if_addr;
    req_size  = pick_data ? d_size : 2'd2;
    req_fault = ({1'b0, req_addr} < {1'b0, STARTING_ADDR}) || ({1'b0, req_addr} >= range_end) ||
                (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    if_ready_d   = if_ready_q;
    if_err_d     = if_err_q;
    if_rdata_d   = if_rdata_q;
    d_ready_d    = d_ready_q;
    d_err_d      = d_err_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          gnt_d   = pick_data;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = pick_data && d_unsigned;
          wdata_d = pick_data ? d_wdata : 32'd0;
          if (req_fault) begin
            state_d = DONE;
            if (pick_data) begin
              d_ready_d = 1'b1;
              d_err_d   = 1'b1;
            end else begin
              if_ready_d = 1'b1;
              if_err_d   = 1'b1;
            end
          end else if (!(pick_data && d_we)) begin
            state_d = RD;
          end else if (req_size == 2'd2) begin
            word_d  = d_wdata;
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        state_d = DONE;
        if (gnt_q == GNT_DATA) begin
          d_ready_d = 1'b1;
          d_rdata_d = load_ext;
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = mem_data_out;
        end
      end
      RMW_RD: begin
        word_d  = (mem_data_out & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
        state_d = WR;
      end
      WR: begin
        d_ready_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if_ready_d   = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = 32'd0;
        d_ready_d    = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = 32'd0;
        last_grant_d = gnt_q;
        addr_d       = STARTING_ADDR;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      gnt_q        <= GNT_FETCH;
      addr_q       <= STARTING_ADDR;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= 32'd0;
      word_q       <= 32'd0;
      if_ready_q   <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= 32'd0;
      d_ready_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      if_ready_q   <= if_ready_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ready_q    <= d_ready_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory-side outputs depend only on registers, so reset drops a pending write at once.
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_read_write = (state_q == WR) ? MEM_WRITE : MEM_READ;
  assign mem_data_in    = (state_q == WR) ? word_q : 32'd0;

  assign if_ready = if_ready_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign d_ready  = d_ready_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;
endmodule
